if_fetch_ctrl: RTL and testbench

Instruction-fetch controller between the program counter and the instruction memory port in the pipeline processor. It takes the PC's fetch address, runs a request/grant/response transaction on the instruction memory bus, and loads the returned word into the IF/ID register. It drives the PC's write enable, so the PC advances only when an instruction has been delivered or a redirect arrives. It tolerates variable memory latency, decode-stage stalls and branch flushes in the middle of a fetch.

---
 rtl/if_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: runs one req/gnt/rvalid transaction at a time
// against instruction memory and loads the returned word into the IF/ID register.
module if_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RST_INSTR = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC_Addr,
  output logic              PC_IFWrite,
  input  logic              Flush,
  input  logic              ID_Stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] IF_Instr,
  output logic [ADDR_W-1:0] IF_PC,
  output logic              IF_Valid,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic              drop_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [DATA_W-1:0] if_instr_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic              if_valid_q;

  logic out_free;
  logic deliver_mem;
  logic deliver_hold;

  // Bus handshake: a request transfers on the cycle imem_req & imem_gnt are both
  // high (address sampled then); imem_rvalid qualifies imem_rdata for one cycle
  // and cannot be back-pressured, so a blocked word is parked in the hold buffer.
  assign out_free     = !if_valid_q || !ID_Stall;
  assign deliver_mem  = !rst && (state_q == S_WAIT) && imem_rvalid && !drop_q &&
                        !Flush && out_free;
  assign deliver_hold = !rst && (state_q == S_HOLD) && !Flush && out_free;

  assign imem_req    = !rst && (state_q == S_REQ);
  assign imem_addr   = PC_Addr;
  assign PC_IFWrite  = !rst && (Flush || deliver_mem || deliver_hold);
  assign IF_Instr    = if_instr_q;
  assign IF_PC       = if_pc_q;
  assign IF_Valid    = if_valid_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      drop_q      <= 1'b0;
      req_addr_q  <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      if_instr_q  <= RST_INSTR;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            req_addr_q <= PC_Addr;
            drop_q     <= Flush;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_q <= 1'b0;
            if (drop_q || Flush || out_free) begin
              state_q <= S_REQ;
            end else begin
              hold_addr_q <= req_addr_q;
              hold_data_q <= imem_rdata;
              state_q     <= S_HOLD;
            end
          end else if (Flush) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (Flush || out_free) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      // Flush wins over any delivery so a squashed word never reaches decode.
      if (Flush) begin
        if_valid_q <= 1'b0;
        if_instr_q <= RST_INSTR;
      end else if (deliver_mem) begin
        if_valid_q <= 1'b1;
        if_instr_q <= imem_rdata;
        if_pc_q    <= req_addr_q;
      end else if (deliver_hold) begin
        if_valid_q <= 1'b1;
        if_instr_q <= hold_data_q;
        if_pc_q    <= hold_addr_q;
      end else if (if_valid_q && !ID_Stall) begin
        if_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a PC, a latency-configurable memory and a
// transaction-level reference model, driven by directed and random stimulus.
module tb_if_fetch_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [AW-1:0] PC_Addr = '0;
  logic          PC_IFWrite;
  logic          Flush = 1'b0;
  logic          ID_Stall = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic [DW-1:0] IF_Instr;
  logic [AW-1:0] IF_PC;
  logic          IF_Valid;
  logic [1:0]    dbg_state;

  if_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .PC_Addr    (PC_Addr),
    .PC_IFWrite (PC_IFWrite),
    .Flush      (Flush),
    .ID_Stall   (ID_Stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .IF_Instr   (IF_Instr),
    .IF_PC      (IF_PC),
    .IF_Valid   (IF_Valid),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // environment: program counter and memory
  logic [AW-1:0] pc = '0, pc_reset = '0, flush_tgt = '0;
  logic          mem_busy = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  int            mem_cnt = 0, g_cnt = 0, g_target = 0;
  int            gmin = 0, gmax = 0, lmin = 1, lmax = 1;

  // reference model (transaction level)
  logic          m_init = 1'b0, m_busy = 1'b0, m_stale = 1'b0;
  logic          m_valid = 1'b0, m_pc_known = 1'b0;
  logic [AW-1:0] m_req_addr = '0, m_pc = '0;
  logic [DW-1:0] m_instr = '0;
  logic [AW-1:0] park_addr_q[$];
  logic [DW-1:0] park_data_q[$];

  // scoreboard: deliveries the model expects to appear on IF/ID
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] log_q[$];
  logic          prev_valid = 1'b0;
  logic [AW-1:0] prev_pc = '0;

  // per-cycle snapshots and counters for directed checks
  logic          s_req, s_pcw, s_valid;
  logic [AW-1:0] s_addr, s_ifpc;
  logic [DW-1:0] s_instr;
  logic [1:0]    s_state;
  int            cnt_req, cnt_pcw, cnt_rvalid, cnt_pcw_ne;
  logic [15:0]   vhist;
  int            stall_pct;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic          out_free, resp, deliver, had_park, exp_req;
    logic          req_s, gnt_s, rv_s, pcw_s, flush_s, rst_s;
    logic [AW-1:0] d_addr, addr_s;
    logic [DW-1:0] d_data;
    @(negedge clk);
    PC_Addr     = pc;
    imem_gnt    = !mem_busy && (g_cnt >= g_target);
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? ~mem_addr : $urandom();
    #2;
    s_req = imem_req; s_pcw = PC_IFWrite; s_valid = IF_Valid; s_addr = imem_addr;
    s_ifpc = IF_PC; s_instr = IF_Instr; s_state = dbg_state;
    if (imem_req) cnt_req++;
    if (PC_IFWrite) cnt_pcw++;
    if (imem_rvalid) cnt_rvalid++;
    if (PC_IFWrite != imem_rvalid) cnt_pcw_ne++;
    vhist = {vhist[14:0], IF_Valid};

    // scoreboard: every new instruction on IF/ID must be the next expected one
    if (m_init && IF_Valid && (!prev_valid || IF_PC != prev_pc)) begin
      log_q.push_back(IF_PC);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL delivery: IF_PC %h appeared, expected no delivery", IF_PC);
      end else begin
        check("delivery_pc", IF_PC, exp_q.pop_front());
      end
    end
    prev_valid = IF_Valid;
    prev_pc    = IF_PC;

    // model: what the outputs must be this cycle
    out_free = !m_valid || !ID_Stall;
    resp     = m_busy && imem_rvalid;
    had_park = park_addr_q.size() != 0;
    exp_req  = !rst && !m_busy && !had_park;
    deliver  = 1'b0;
    d_addr   = '0;
    d_data   = '0;
    if (m_init && !rst && !Flush && out_free) begin
      if (had_park) begin
        deliver = 1'b1; d_addr = park_addr_q[0]; d_data = park_data_q[0];
      end else if (resp && !m_stale) begin
        deliver = 1'b1; d_addr = m_req_addr; d_data = imem_rdata;
      end
    end
    if (m_init || rst) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      check("PC_IFWrite", 32'(PC_IFWrite), 32'(!rst && (Flush || deliver)));
    end
    if (exp_req) check("imem_addr", imem_addr, pc);
    if (m_init) begin
      check("IF_Valid", 32'(IF_Valid), 32'(m_valid));
      check("IF_Instr", IF_Instr, m_instr);
      if (m_pc_known) check("IF_PC", IF_PC, m_pc);
      if (IF_Valid) check("IF_Instr_vs_PC", IF_Instr, ~IF_PC);
    end
    if (deliver) exp_q.push_back(d_addr);

    // model: advance
    if (rst) begin
      m_busy = 1'b0; m_stale = 1'b0;
      park_addr_q.delete(); park_data_q.delete();
      m_valid = 1'b0; m_instr = '0; m_pc = '0; m_pc_known = 1'b1; m_init = 1'b1;
    end else if (m_init) begin
      if (Flush) begin
        m_valid = 1'b0; m_instr = '0; m_pc_known = 1'b0;
      end else if (deliver) begin
        m_valid = 1'b1; m_instr = d_data; m_pc = d_addr; m_pc_known = 1'b1;
      end else if (m_valid && !ID_Stall) begin
        m_valid = 1'b0;
      end
      if (had_park && (Flush || out_free)) begin
        void'(park_addr_q.pop_front());
        void'(park_data_q.pop_front());
      end
      if (exp_req && imem_gnt) begin
        m_busy = 1'b1; m_req_addr = pc; m_stale = Flush;
      end else if (resp) begin
        m_busy = 1'b0;
        if (!m_stale && !Flush && !out_free) begin
          park_addr_q.push_back(m_req_addr);
          park_data_q.push_back(imem_rdata);
        end
        m_stale = 1'b0;
      end else if (m_busy && Flush) begin
        m_stale = 1'b1;
      end
    end

    req_s = imem_req; addr_s = imem_addr; gnt_s = imem_gnt; rv_s = imem_rvalid;
    pcw_s = PC_IFWrite; flush_s = Flush; rst_s = rst;
    @(posedge clk);
    #1;
    if (rst_s) pc = pc_reset;
    else if (pcw_s) pc = flush_s ? flush_tgt : pc + 32'd4;
    if (rv_s) mem_busy = 1'b0;
    if (req_s && gnt_s) begin
      mem_busy = 1'b1;
      mem_addr = addr_s;
      mem_cnt  = int'($urandom_range(lmax, lmin)) - 1;
      g_cnt    = 0;
      g_target = int'($urandom_range(gmax, gmin));
    end else begin
      if (req_s) g_cnt++;
      if (mem_busy && mem_cnt > 0) mem_cnt--;
    end
  endtask

  task automatic mem_clear(input int gn, input int gx, input int ln, input int lx);
    gmin = gn; gmax = gx; lmin = ln; lmax = lx;
    mem_busy = 1'b0; mem_cnt = 0; g_cnt = 0;
    g_target = int'($urandom_range(gmax, gmin));
  endtask

  task automatic do_reset(input logic [AW-1:0] rpc);
    pc_reset = rpc;
    rst = 1'b1; Flush = 1'b0; ID_Stall = 1'b0;
    step();
    rst = 1'b0;
    check("rst_IF_Valid", 32'(IF_Valid), 32'd0);
    check("rst_IF_Instr", IF_Instr, 32'h0000_0000);
    check("rst_IF_PC", IF_PC, 32'h0000_0000);
    check("rst_state", 32'(dbg_state), 32'd0);
    log_q.delete();
    cnt_req = 0; cnt_pcw = 0; cnt_rvalid = 0; cnt_pcw_ne = 0; vhist = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // zero-wait memory streaming from 0x2ff4
    mem_clear(0, 0, 1, 1);
    do_reset(32'h2ff4);
    repeat (7) step();
    check("t1_count", 32'(log_q.size()), 32'd3);
    check("t1_pc0", log_at(0), 32'h2ff4);
    check("t1_pc1", log_at(1), 32'h2ff8);
    check("t1_pc2", log_at(2), 32'h2ffc);
    check("t1_valid_pulses", 32'(vhist[6:0]), 32'h15);
    check("t1_pcw_count", 32'(cnt_pcw), 32'd3);
    check("t1_pcw_eq_rvalid", 32'(cnt_pcw_ne), 32'd0);

    // slow grant and slow response
    mem_clear(2, 2, 4, 4);
    do_reset(32'h100);
    repeat (7) step();
    check("t2_req_cycles", 32'(cnt_req), 32'd3);
    check("t2_pcw_cycles", 32'(cnt_pcw), 32'd1);
    step();
    check("t2_count", 32'(log_q.size()), 32'd1);
    check("t2_pc0", log_at(0), 32'h100);

    // decode stall parks a response in HOLD
    mem_clear(0, 0, 1, 1);
    do_reset(32'h200);
    step();
    ID_Stall = 1'b1;
    repeat (4) step();
    check("t3_hold_state", 32'(s_state), 32'd2);
    step();
    check("t3_held_valid", 32'(s_valid), 32'd1);
    check("t3_held_pc", s_ifpc, 32'h200);
    check("t3_held_instr", s_instr, ~32'h200);
    ID_Stall = 1'b0;
    step();
    check("t3_release_pcw", 32'(s_pcw), 32'd1);
    step();
    check("t3_next_pc", s_ifpc, 32'h204);
    check("t3_pc_advanced", s_addr, 32'h208);
    check("t3_req", 32'(s_req), 32'd1);

    // flush while waiting; old word arrives two cycles later
    mem_clear(0, 0, 3, 3);
    do_reset(32'h1000);
    step();
    Flush = 1'b1; flush_tgt = 32'h3000;
    step();
    check("t4_flush_pcw", 32'(s_pcw), 32'd1);
    Flush = 1'b0;
    repeat (7) step();
    check("t4_count", 32'(log_q.size()), 32'd1);
    check("t4_pc0", log_at(0), 32'h3000);

    // flush coincident with grant
    mem_clear(0, 0, 1, 1);
    do_reset(32'h1000);
    Flush = 1'b1; flush_tgt = 32'h4000;
    step();
    Flush = 1'b0;
    step();
    check("t5a_valid_c1", 32'(s_valid), 32'd0);
    step();
    check("t5a_valid_c2", 32'(s_valid), 32'd0);
    check("t5a_redirect_addr", s_addr, 32'h4000);
    repeat (2) step();
    check("t5a_count", 32'(log_q.size()), 32'd1);
    check("t5a_pc0", log_at(0), 32'h4000);

    // flush coincident with rvalid
    mem_clear(0, 0, 1, 1);
    do_reset(32'h1000);
    ID_Stall = 1'b1;
    repeat (3) step();
    Flush = 1'b1; flush_tgt = 32'h5000;
    step();
    check("t5b_flush_pcw", 32'(s_pcw), 32'd1);
    Flush = 1'b0;
    step();
    check("t5b_valid_after", 32'(s_valid), 32'd0);
    check("t5b_redirect_addr", s_addr, 32'h5000);
    repeat (2) step();
    check("t5b_count", 32'(log_q.size()), 32'd2);
    check("t5b_pc0", log_at(0), 32'h1000);
    check("t5b_pc1", log_at(1), 32'h5000);
    ID_Stall = 1'b0;

    // reset in WAIT followed by a stray response
    mem_clear(0, 0, 3, 3);
    do_reset(32'h0);
    pc = 32'h7000;
    step();
    rst = 1'b1;
    step();
    check("t6_rst_req", 32'(s_req), 32'd0);
    check("t6_rst_pcw", 32'(s_pcw), 32'd0);
    rst = 1'b0;
    step();
    check("t6_valid", 32'(s_valid), 32'd0);
    check("t6_instr", s_instr, 32'h0);
    check("t6_ifpc", s_ifpc, 32'h0);
    check("t6_req", 32'(s_req), 32'd1);
    check("t6_addr", s_addr, 32'h0);
    log_q.delete();
    step();
    check("t6_stray_pcw", 32'(s_pcw), 32'd0);
    check("t6_stray_state", 32'(s_state), 32'd0);
    repeat (5) step();
    check("t6_count", 32'(log_q.size()), 32'd1);
    check("t6_pc0", log_at(0), 32'h0);

    // random traffic, light then heavy decode stalls
    mem_clear(0, 3, 1, 4);
    do_reset($urandom() & 32'hFFFF_FFFC);
    for (int phase = 0; phase < 2; phase++) begin
      stall_pct = (phase == 0) ? 30 : 75;
      for (int i = 0; i < 1500; i++) begin
        rst       = ($urandom_range(0, 199) == 0);
        Flush     = ($urandom_range(0, 99) < 6);
        flush_tgt = $urandom() & 32'hFFFF_FFFC;
        ID_Stall  = (int'($urandom_range(0, 99)) < stall_pct);
        if (rst) pc_reset = $urandom() & 32'hFFFF_FFFC;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
